// File: rtl/sd_modulator.sv
// sd_modulator
//   First-order sigma-delta modulator for the DAC datapath. A WIDTH-bit
//   accumulator adds the active code every clock. Its registered carry-out
//   is the 1-bit bitstream, with mean density code/2^WIDTH. Input samples
//   enter a one-entry valid/ready holding register. They are moved into the
//   active code only at oversampling-frame boundaries, which occur every
//   2^OSR_LOG2 clocks.
//
//   Optional feature macro: SD_DITHER_EN. When it is defined, a 16-bit
//   Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) feeds its bit 0
//   into the adder carry-in. This breaks idle tones.
//
// Parameters
//   WIDTH    : code / accumulator width (>= 2)
//   OSR_LOG2 : log2 of clocks per input sample (>= 1)
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   din        : unsigned input sample
//   din_valid  : din valid this cycle
//   din_ready  : holding register empty (accept on din_valid && din_ready)
//   dout       : registered bitstream (accumulator carry-out)
//   frame_tick : one-cycle pulse, first cycle the new frame's code is in use
//   underrun   : one-cycle pulse with frame_tick when no sample was pending
module sd_modulator #(
  parameter int WIDTH    = 8,
  parameter int OSR_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             frame_tick,
  output logic             underrun
);

  localparam logic [OSR_LOG2-1:0] CNT_MAX = {OSR_LOG2{1'b1}};
  localparam logic [OSR_LOG2-1:0] CNT_ONE = OSR_LOG2'(1'b1);

  logic [WIDTH-1:0]    acc_r;
  logic [WIDTH-1:0]    code_r;
  logic [WIDTH-1:0]    hold_r;
  logic                hold_full_r;
  logic [OSR_LOG2-1:0] cnt_r;
  logic                dout_r;
  logic                frame_tick_r;
  logic                underrun_r;

  logic                cin_s;
  logic [WIDTH:0]      sum_s;
  logic                boundary_s;
  logic                accept_s;

`ifdef SD_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_r;

  // Feedback for x^16+x^14+x^13+x^11+1 (bit 15 is the x^16 stage).
  function automatic logic lfsr_feedback(input logic [15:0] state);
    return state[15] ^ state[13] ^ state[12] ^ state[10];
  endfunction

  // Dither LFSR, free-running every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_feedback(lfsr_r)};
    end
  end

  assign cin_s = lfsr_r[0];
`else
  assign cin_s = 1'b0;
`endif

  // The adder is widened by one bit so that its MSB is the carry/pulse.
  assign sum_s      = {1'b0, acc_r} + {1'b0, code_r} + {{WIDTH{1'b0}}, cin_s};
  assign boundary_s = (cnt_r == CNT_MAX);
  assign accept_s   = din_valid & ~hold_full_r;

  assign din_ready  = ~hold_full_r;
  assign dout       = dout_r;
  assign frame_tick = frame_tick_r;
  assign underrun   = underrun_r;

  // Accumulator and registered bitstream output.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= {WIDTH{1'b0}};
      dout_r <= 1'b0;
    end else begin
      acc_r  <= sum_s[WIDTH-1:0];
      dout_r <= sum_s[WIDTH];
    end
  end

  // Frame counter and the frame_tick/underrun pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= {OSR_LOG2{1'b0}};
      frame_tick_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      cnt_r        <= cnt_r + CNT_ONE;
      frame_tick_r <= boundary_s;
      underrun_r   <= boundary_s & ~hold_full_r;
    end
  end

  // Holding register and active code. A boundary with a full hold drains it.
  // Acceptance is only possible while hold is empty, so the two branches
  // never compete. A sample accepted on an empty-hold boundary waits for the
  // next boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_r      <= {WIDTH{1'b0}};
      hold_r      <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
    end else if (boundary_s && hold_full_r) begin
      code_r      <= hold_r;
      hold_full_r <= 1'b0;
    end else if (accept_s) begin
      hold_r      <= din;
      hold_full_r <= 1'b1;
    end else begin
      hold_full_r <= hold_full_r;
    end
  end

endmodule

// File: doc/sd_modulator.md
# sd_modulator

Parametrised first-order sigma-delta modulator, the successor to the fixed 4-bit registered adder in the DAC datapath. A WIDTH-bit accumulator adds the active input code every clock; the registered carry-out is the 1-bit DAC bitstream, with mean density code/2^WIDTH. Input samples arrive through a one-entry valid/ready holding register. They are applied at oversampling-frame boundaries of 2^OSR_LOG2 clocks.

## Interface
- WIDTH, 8: code and accumulator width in bits (≥2).
- OSR_LOG2, 4: log2 of clocks per input sample (frame length 2^OSR_LOG2, ≥1).

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  unsigned input sample.
- din_valid  in  1  din is valid this cycle.
- din_ready  out  1  holding register empty; a sample is accepted when din_valid && din_ready at the rising edge.
- dout  out  1  registered bitstream (accumulator carry-out).
- frame_tick  out  1  one-cycle pulse; the first cycle in which a new frame's code is used by the adder.
- underrun  out  1  one-cycle pulse, coincident with frame_tick, when no sample was pending at the boundary.

## Operation
- State: acc[WIDTH-1:0], code[WIDTH-1:0], hold[WIDTH-1:0], hold_full, cnt[OSR_LOG2-1:0], and the registered outputs.
- Reset values: acc=0, code=0, hold=0, hold_full=0, cnt=0, dout=0, frame_tick=0, underrun=0. din_ready is ~hold_full, so it is 1 out of reset.
- Every cycle: {carry, acc} <= acc + code + cin, computed at WIDTH+1 bits. dout <= carry. cin=0 unless dither is compiled in.
- Accumulator wrap-around is modulo 2^WIDTH; the carry is the output pulse.
- Handshake: accept when din_valid && !hold_full, then hold <= din and hold_full <= 1. din_ready drops the next cycle. din is ignored while hold_full=1.
- cnt increments every cycle and wraps from 2^OSR_LOG2-1 to 0. The cycle where cnt==max is the boundary.
- At a boundary edge with hold_full=1: code <= hold and hold_full <= 0; underrun stays 0.
- At a boundary edge with hold_full=0: code is kept, and underrun <= 1 for one cycle.
- A sample accepted on the boundary edge itself enters hold. It does not reach code until the next boundary, and underrun still pulses for the current boundary.
- frame_tick <= (cnt==max), so frame_tick is high for exactly one cycle per frame.
- Reset mid-operation aborts everything: the pending hold is discarded, and the accumulator phase and frame counter restart.

## Timing
- Sample to code: the accepted sample is applied at the next boundary edge, after 1 to 2^OSR_LOG2 cycles.
- Code to adder: the new code is used starting at the edge after frame_tick rises.
- Adder to dout: 1 cycle, because dout is registered.
- din_ready to accept: din_ready rises again the cycle after a boundary that emptied hold. The maximum sustained rate is one sample per frame.
- Boundary cases:
  - code=0 without dither: dout stays at 0.
  - code=2^WIDTH-1: dout is 1 for 2^WIDTH-1 of every 2^WIDTH cycles.
  - The output density over any 2^WIDTH-cycle window with a constant code equals code exactly.

## Configuration
- SD_DITHER_EN defined:
  - Adds a 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1 and seed 16'hACE1, reset to the seed.
  - The LFSR advances every cycle. Its bit 0 drives cin.
  - This breaks idle tones. The mean density becomes (code+0.5)/2^WIDTH, and code=0 produces nonzero dout.
- SD_DITHER_EN undefined: no LFSR is present, cin is tied to 0, and the output is the deterministic pattern above.

## Test plan
- Reset: assert rst for 3 cycles with din_valid=1 → dout=0, frame_tick=0, underrun=0, din_ready=1, and no sample is captured.
- WIDTH=8, OSR_LOG2=4, load din=0x80 (dither off) → after frame_tick, dout alternates 0,1 and shows exactly 128 ones in 256 cycles.
- Load din=0x40 → after frame_tick, dout=1 every 4th cycle, and acc follows 0x40, 0x80, 0xC0, 0x00 with a carry.
- Back-to-back samples 0x10 then 0x20 with din_valid held high:
  - 0x10 is accepted and din_ready goes low.
  - At the boundary, code=0x10 and din_ready returns to 1 one cycle later.
  - 0x20 is then accepted and applied at the following boundary with underrun=0.
- No sample presented for one frame → underrun pulses together with frame_tick, code keeps its previous value, and dout density is unchanged.
- Reset asserted mid-frame with hold_full=1 → hold is discarded, code=0, din_ready=1, and the first frame_tick comes 16 cycles after rst is released.
